// File: rtl/code_converter_scheduler.sv
// Round-robin front-end that time-shares one external 4-bit code converter among
// NREQ requesters and returns each converted code over a valid/ready response port.
module code_converter_scheduler #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [2*NREQ-1:0]         req_mode,
  input  logic [4*NREQ-1:0]         req_data,
  output logic [NREQ-1:0]           gnt,
  output logic                      A,
  output logic                      B,
  output logic                      C,
  output logic                      D,
  output logic                      S2,
  output logic                      S1,
  input  logic [3:0]                o0,
  input  logic [3:0]                o1,
  input  logic [3:0]                o2,
  input  logic [3:0]                o3,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [3:0]                rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;

  logic           found;
  logic [IDW-1:0] sel;
  int             idx;
  logic [1:0]     sel_mode;
  logic [3:0]     sel_data;
  logic           operand_ok;
  logic [IDW-1:0] next_ptr;
  logic [NREQ-1:0] grant_vec;
  logic [3:0]     conv_out;

  // First requester at or after ptr, searching upward with wrap-around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IDW'(idx)]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_mode       = req_mode[2*sel +: 2];
    sel_data       = req_data[4*sel +: 4];
    next_ptr       = (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
    grant_vec      = '0;
    grant_vec[sel] = found;
    case (sel_mode)
      2'b01:   operand_ok = (sel_data <= 4'd9);
      2'b11:   operand_ok = (sel_data >= 4'd3) && (sel_data <= 4'd12);
      default: operand_ok = 1'b1;
    endcase
  end

  always_comb begin
    case ({S2, S1})
      2'b00:   conv_out = o0;
      2'b01:   conv_out = o1;
      2'b10:   conv_out = o2;
      default: conv_out = o3;
    endcase
  end

  // Invalid operands skip the converter entirely, so A..D and S2/S1 keep the last
  // conversion's values and the error response is ready alongside the grant pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      {A, B, C, D} <= 4'b0000;
      {S2, S1}  <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 4'b0000;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt <= '0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            gnt    <= grant_vec;
            rsp_id <= sel;
            ptr    <= next_ptr;
            busy   <= 1'b1;
            if (operand_ok) begin
              {A, B, C, D} <= sel_data;
              {S2, S1}     <= sel_mode;
              cnt          <= '0;
              state        <= ST_SETTLE;
            end else begin
              rsp_err   <= 1'b1;
              rsp_data  <= 4'b0000;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == CW'(SETTLE-1)) begin
            rsp_data  <= conv_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
